// File: rtl/user_code_loader.sv
// Loads a framed byte stream (SYNC, N, N words high byte first, CHK) into the
// writable instruction memory. Optional macro LOADER_TIMEOUT_EN adds an inter-byte timeout.
module user_code_loader #(
    parameter int          DEPTH          = 32,
    parameter int          ADDR_W         = 5,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [15:0]       wr_data_o,
    output logic              cpu_hold_o,
    output logic              load_done_o,
    output logic              load_error_o,
    output logic [5:0]        words_loaded_o
);

    if ((2 ** ADDR_W) < DEPTH || DEPTH < 1 || DEPTH > 63 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("user_code_loader: invalid parameter combination");
    end

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    typedef enum logic [2:0] {IDLE, HDR, COUNT, HI, LO, CHK, DONE, ERR} state_t;

    state_t              state_q, state_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [5:0]          words_q, words_d;
    logic [5:0]          n_q, n_d;
    logic [7:0]          hi_q, hi_d;
    logic [7:0]          cksum_q, cksum_d;
    logic                rx_ready;
    logic                accept;

    always_comb begin
        rx_ready = (state_q == HDR) || (state_q == COUNT) || (state_q == HI) ||
                   (state_q == LO)  || (state_q == CHK);
        accept   = rx_valid_i && rx_ready;
    end

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        hold_d    = hold_q;
        done_d    = done_q;
        err_d     = err_q;
        words_d   = words_q;
        n_d       = n_q;
        hi_d      = hi_q;
        cksum_d   = cksum_q;
`ifdef LOADER_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            IDLE: if (load_start_i) begin
                state_d = HDR;
                hold_d  = 1'b1;
                done_d  = 1'b0;
                err_d   = 1'b0;
                words_d = '0;
                cksum_d = '0;
            end
            // Non-sync bytes are dropped so a sender can resync mid-stream.
            HDR: if (accept && rx_data_i == SYNC_BYTE) state_d = COUNT;
            COUNT: if (accept) begin
                if (rx_data_i == 8'd0 || rx_data_i > DEPTH_B) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    n_d     = rx_data_i[5:0];
                    state_d = HI;
                end
            end
            HI: if (accept) begin
                hi_d    = rx_data_i;
                cksum_d = cksum_q + rx_data_i;
                state_d = LO;
            end
            LO: if (accept) begin
                wr_en_d   = 1'b1;
                wr_addr_d = ADDR_W'(words_q);
                wr_data_d = {hi_q, rx_data_i};
                cksum_d   = cksum_q + rx_data_i;
                words_d   = words_q + 6'd1;
                state_d   = (words_q + 6'd1 == n_q) ? CHK : HI;
            end
            CHK: if (accept) begin
                if (rx_data_i == cksum_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end else begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef LOADER_TIMEOUT_EN
        // Idle-gap counter; HDR waits forever for a sender to show up.
        if (state_q == COUNT || state_q == HI || state_q == LO || state_q == CHK) begin
            if (accept) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                tmo_d   = '0;
                state_d = ERR;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            words_q   <= '0;
            n_q       <= '0;
            hi_q      <= '0;
            cksum_q   <= '0;
`ifdef LOADER_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
            words_q   <= words_d;
            n_q       <= n_d;
            hi_q      <= hi_d;
            cksum_q   <= cksum_d;
`ifdef LOADER_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign rx_ready_o     = rx_ready;
    assign wr_en_o        = wr_en_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign cpu_hold_o     = hold_q;
    assign load_done_o    = done_q;
    assign load_error_o   = err_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_user_code_loader.sv
// Self-checking bench for user_code_loader: frame table plus hand-written
// full-load, mid-load reset and (with LOADER_TIMEOUT_EN) timeout sequences.
module tb_user_code_loader;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    logic [5:0]    words_loaded;

    user_code_loader #(.DEPTH(32), .ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(20)) dut (
        .clk_i(clk), .rst_i(rst), .load_start_i(load_start),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .cpu_hold_o(cpu_hold), .load_done_o(load_done), .load_error_o(load_error),
        .words_loaded_o(words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [AW+15:0] expq[$];

    typedef struct {
        string       name;
        int          nb;
        logic [63:0] bytes;
        int          nw;
        logic [63:0] words;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(string nm, int nb, logic [63:0] b, int nw, logic [63:0] w,
                                logic d, logic e);
        vec_t v;
        v.name = nm; v.nb = nb; v.bytes = b; v.nw = nw; v.words = w; v.done = d; v.err = e;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, writes matched against the queue.
    task automatic step();
        logic [AW+15:0] e;
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0d data=%h expected none", wr_addr, wr_data);
            end else begin
                e = expq.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                             wr_addr, wr_data, e[AW+15:16], e[15:0]);
                end
            end
        end
    endtask

    task automatic send(logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
    endtask

    task automatic start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_ready", 32'(rx_ready), 32'd1);
        chk("start_flags", {load_done, load_error, words_loaded}, 32'd0);
    endtask

    task automatic finish_session(string nm, logic d, logic e, logic [5:0] w);
        rx_valid = 1'b0;
        repeat (3) step();
        chk({nm, "_qempty"}, 32'(expq.size()), 32'd0);
        chk({nm, "_done"}, 32'(load_done), 32'(d));
        chk({nm, "_err"}, 32'(load_error), 32'(e));
        chk({nm, "_hold"}, 32'(cpu_hold), 32'(e));
        chk({nm, "_words"}, 32'(words_loaded), 32'(w));
        chk({nm, "_ready"}, 32'(rx_ready), 32'd0);
    endtask

    initial begin
        logic [7:0]  cs;
        logic [15:0] w;

        vecs[0] = mk("good2",  7, 64'hA502_3000_8C08_C400, 2, 64'h3000_8C08_0000_0000, 1'b1, 1'b0);
        vecs[1] = mk("resync", 7, 64'h00FF_A501_5001_5100, 1, 64'h5001_0000_0000_0000, 1'b1, 1'b0);
        vecs[2] = mk("badchk", 5, 64'hA501_1122_0000_0000, 1, 64'h1122_0000_0000_0000, 1'b0, 1'b1);
        vecs[3] = mk("n0",     2, 64'hA500_0000_0000_0000, 0, 64'h0,                   1'b0, 1'b1);
        vecs[4] = mk("n33",    2, 64'hA521_0000_0000_0000, 0, 64'h0,                   1'b0, 1'b1);
        vecs[5] = mk("wrap",   5, 64'hA501_FF02_0100_0000, 1, 64'hFF02_0000_0000_0000, 1'b1, 1'b0);

        // Reset together with load_start: reset must win.
        rst = 1'b1; load_start = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        step(); step();
        rst = 1'b0; load_start = 1'b0;
        chk("rst_outputs", {rx_ready, wr_en, wr_addr, cpu_hold, load_done, load_error},
            32'd0);
        chk("rst_wdata", 32'(wr_data), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        step();
        chk("rst_idle_ready", 32'(rx_ready), 32'd0);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < vecs[i].nw; k++)
                expq.push_back({AW'(k), vecs[i].words[63-16*k -: 16]});
            start();
            for (int k = 0; k < vecs[i].nb; k++)
                send(vecs[i].bytes[63-8*k -: 8]);
            finish_session(vecs[i].name, vecs[i].done, vecs[i].err, 6'(vecs[i].nw));
        end

        // Full 32-word load, bytes back to back.
        start();
        send(8'hA5); send(8'd32);
        cs = 8'h00;
        for (int i = 0; i < 32; i++) begin
            w = 16'($urandom);
            expq.push_back({AW'(i), w});
            send(w[15:8]); send(w[7:0]);
            cs = cs + w[15:8] + w[7:0];
        end
        send(cs);
        finish_session("full32", 1'b1, 1'b0, 6'd32);

        // Reset after word 10 has been written: no further writes.
        start();
        send(8'hA5); send(8'd32);
        for (int i = 0; i < 10; i++) begin
            w = 16'($urandom);
            expq.push_back({AW'(i), w});
            send(w[15:8]); send(w[7:0]);
        end
        chk("midrst_words_before", 32'(words_loaded), 32'd10);
        send(8'h12);
        rst = 1'b1; rx_data = 8'h34;
        step();
        rst = 1'b0;
        chk("midrst_hold", 32'(cpu_hold), 32'd0);
        chk("midrst_ready", 32'(rx_ready), 32'd0);
        for (int i = 0; i < 5; i++) send(8'(i + 8'h40));
        rx_valid = 1'b0;
        step();
        chk("midrst_qempty", 32'(expq.size()), 32'd0);
        chk("midrst_flags", {load_done, load_error, words_loaded}, 32'd0);

`ifdef LOADER_TIMEOUT_EN
        // 19-cycle stall survives.
        expq.push_back({AW'(0), 16'hAB00});
        start();
        send(8'hA5); send(8'h01); send(8'hAB);
        rx_valid = 1'b0;
        repeat (19) step();
        chk("tmo19_err", 32'(load_error), 32'd0);
        send(8'h00); send(8'hAB);
        finish_session("tmo19", 1'b1, 1'b0, 6'd1);

        // 20-cycle stall errors out.
        start();
        send(8'hA5); send(8'h01); send(8'hAB);
        rx_valid = 1'b0;
        repeat (19) step();
        chk("tmo20_pre_err", 32'(load_error), 32'd0);
        step();
        chk("tmo20_err", 32'(load_error), 32'd1);
        finish_session("tmo20", 1'b0, 1'b1, 6'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/user_code_loader.md
Name: user_code_loader

Overview:
- Writer-side counterpart to the i281 user code ROM banks.
- Receives a framed byte stream and assembles 16-bit instruction words in the format opcode[15:12], rA[11:10], rB[9:8], imm[7:0].
- Writes each word into the writable instruction memory: words 0-15 go to the low bank, words 16-31 to the high bank.
- Holds the CPU in reset while loading, then releases it.

Parameters:
- DEPTH, 32, instruction words addressable (low + high bank).
- ADDR_W, 5, width of wr_addr; must satisfy 2**ADDR_W >= DEPTH.
- SYNC_BYTE, 8'hA5, frame header byte.
- TIMEOUT_CYCLES, 1000, inter-byte timeout in clocks (used only with LOADER_TIMEOUT_EN).

Ports:
- Clock  input  1  system clock, all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle pulse; begins a load session.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts byte this cycle.
- wr_en  output  1  one-cycle instruction memory write strobe.
- wr_addr  output  ADDR_W  word address; bit 4 selects the high bank.
- wr_data  output  16  instruction word.
- cpu_hold  output  1  holds the CPU in reset while high.
- load_done  output  1  sticky: last session completed successfully.
- load_error  output  1  sticky: last session failed.
- words_loaded  output  6  count of words written in the current or last session.

Behaviour:
- Clocking and reset:
  - Single clock; Reset is synchronous and active-high.
  - Reset values: state=IDLE, rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, load_done=0, load_error=0, words_loaded=0, checksum=0.
- Byte handshake:
  - A byte transfers on a cycle where rx_valid && rx_ready.
  - rx_ready=1 in HDR, COUNT, HI, LO, CHK; rx_ready=0 in IDLE, DONE, ERR.
- Frame format: SYNC_BYTE, N, then N words sent high byte first, then CHK byte.
  - N must be 1..DEPTH.
  - CHK is the 8-bit modulo-256 sum of all 2N payload bytes.
- States:
  - IDLE: load_start -> HDR. On entry to HDR: cpu_hold=1, load_done=0, load_error=0, words_loaded=0, checksum=0, word pointer=0.
  - HDR: byte==SYNC_BYTE -> COUNT. Any other byte is discarded and the state stays HDR (resync).
  - COUNT: N==0 or N>DEPTH -> ERR. Otherwise latch N -> HI.
  - HI: latch byte into hi register, checksum+=byte -> LO.
  - LO:
    - Form the word {hi, byte}; checksum+=byte.
    - Next cycle: wr_en=1 for exactly one cycle, wr_addr=pointer, wr_data=word.
    - Then increment pointer and words_loaded.
    - Next state: CHK if words_loaded==N after increment, else HI.
  - CHK: byte==checksum -> DONE, else -> ERR.
  - DONE: load_done=1, cpu_hold=0 -> IDLE next cycle.
  - ERR: load_error=1, cpu_hold stays 1 -> IDLE next cycle. The CPU remains held until a successful load or Reset.
- Write latency: wr_en asserts on the cycle after the LO byte is accepted.
- Memory contents:
  - Words already written during a failed session are not rolled back.
  - Memory beyond N is untouched.
- load_start handling:
  - Ignored outside IDLE.
  - load_start in the same cycle as Reset: Reset wins.
- Reset mid-session: return to IDLE immediately, cpu_hold=0, no further wr_en.
- Back-to-back bytes (rx_valid held high) are accepted every cycle with no bubbles.
- Checksum arithmetic is 8-bit wrap-around; carry is discarded.
- wr_addr never exceeds DEPTH-1.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - A counter runs in COUNT, HI, LO, CHK and clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES with no accepted byte -> ERR.
  - HDR does not time out.
- Undefined: no counter; the loader waits indefinitely for each byte.

Test Plan:
- Good 2-word load: load_start, then A5,02,30,00,8C,08, CHK=0xC4 -> wr_en at addr0=16'h3000 and addr1=16'h8C08; load_done=1, cpu_hold falls, words_loaded=2.
- Sync resync: load_start, then 00,FF,A5,01,50,01, CHK=0x51 -> 00 and FF discarded; addr0=16'h5001; load_done=1.
- Bad checksum: A5,01,11,22 with CHK 0x00 -> one write; load_error=1, cpu_hold stays 1, load_done=0.
- Count out of range: A5 then N=0 -> load_error=1, no wr_en; repeat with N=33 -> same result.
- Full 32-word load with rx_valid held high and bytes accepted every cycle -> 32 writes at addresses 0..31, wr_addr bit4=1 from word 16, correct CHK gives load_done=1; Reset asserted mid-load at word 10 -> IDLE next cycle, cpu_hold=0, no further writes.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=20: A5,01,AB then rx_valid low for 20 cycles -> ERR, load_error=1; a stall of 19 cycles does not error.
